// File: rtl/out_ser_cell.sv
// Output serialiser cell: shifts a SER_WIDTH-bit fabric word out to a pad, LSB first,
// with a registered output enable and a combinational bypass path selected by OSEL.
module out_ser_cell #(
  parameter int   SER_WIDTH = 4,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic                 IQC,
  input  logic                 QRT,
  input  logic [SER_WIDTH-1:0] F2A_DATA,
  input  logic                 F2A_VALID,
  input  logic                 OE_REQ,
  input  logic                 OSEL,
  output logic                 F2A_READY,
  output logic                 BUSY,
  (* iopad_external_pin *) output logic OQI_out,
  (* iopad_external_pin *) output logic OE_out
);

  localparam int CW = (SER_WIDTH > 1) ? $clog2(SER_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SER_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [SER_WIDTH-1:0] r_shift;
  logic                 r_pad;
  logic                 r_oe;

  logic                 w_last;
  logic                 w_ready;
  logic                 w_accept;
  logic [CW-1:0]        w_cntNext;

  assign w_last    = (r_cnt == LAST_CNT);
  assign w_ready   = !QRT && ((r_state == IDLE) || w_last);
  assign w_accept  = F2A_VALID && w_ready;
  assign w_cntNext = r_cnt + CW'(1);

  // The word stays in r_shift and the counter selects the next bit, so the
  // pad register always shows bit k while the counter reads k.
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pad   <= IDLE_VAL;
      r_oe    <= 1'b0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
      r_shift <= F2A_DATA;
      r_pad   <= F2A_DATA[0];
      r_oe    <= OE_REQ;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
        r_pad   <= IDLE_VAL;
        r_oe    <= 1'b0;
      end else begin
        r_cnt <= w_cntNext;
        r_pad <= r_shift[w_cntNext];
      end
    end
  end

  assign F2A_READY = w_ready;
  assign BUSY      = (r_state == SHIFT);
  assign OQI_out   = OSEL ? F2A_DATA[0] : r_pad;
  assign OE_out    = OSEL ? OE_REQ      : r_oe;

endmodule

// File: tb/tb_out_ser_cell.sv
// Scoreboard bench for out_ser_cell: the driver predicts each accepted word's pad bits
// into a queue, and an independent monitor pops and compares them every cycle.
module tb_out_ser_cell;

  localparam int   W    = 4;
  localparam logic IDLE = 1'b0;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         valid = 1'b0;
  logic         oeReq = 1'b0;
  logic         osel  = 1'b0;
  logic [W-1:0] data  = '0;

  logic ready;
  logic busy;
  logic padOut;
  logic oeOut;

  int passCount  = 0;
  int checkCount = 0;

  // Model: number of bit cycles of the current word still on the pad (including
  // the bit shown now), and the per-cycle {pad, oe} values still to come.
  int         left = 0;
  logic [1:0] expQ[$];

  always #5 clk = ~clk;

  out_ser_cell #(
    .SER_WIDTH(W),
    .IDLE_VAL (IDLE)
  ) dut (
    .IQC      (clk),
    .QRT      (rst),
    .F2A_DATA (data),
    .F2A_VALID(valid),
    .OE_REQ   (oeReq),
    .OSEL     (osel),
    .F2A_READY(ready),
    .BUSY     (busy),
    .OQI_out  (padOut),
    .OE_out   (oeOut)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs on the falling edge and predicts the next rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d,
                               input logic o, input logic s);
    @(negedge clk);
    rst   = r;
    valid = v;
    data  = d;
    oeReq = o;
    osel  = s;
    #1;
    checkOutput("ready", ready, (!r && left <= 1));
    if (s) begin
      checkOutput("bypassPad", padOut, d[0]);
      checkOutput("bypassOe", oeOut, o);
    end
    if (r) begin
      expQ.delete();
      left = 0;
      checkOutput("rstBusy", busy, 1'b0);
      if (!s) begin
        checkOutput("rstPad", padOut, IDLE);
        checkOutput("rstOe", oeOut, 1'b0);
      end
    end else if (v && left <= 1) begin
      for (int k = 0; k < W; k++) expQ.push_back({d[k], o});
      left = W;
    end else if (left > 0) begin
      left--;
    end
  endtask

  // Monitor: one expected entry per cycle while a word is on the pad.
  initial begin
    logic [1:0] e;
    logic       expPad;
    logic       expOe;
    forever begin
      @(posedge clk);
      #1;
      checkOutput("busy", busy, (expQ.size() > 0));
      if (expQ.size() > 0) e = expQ.pop_front();
      else e = {IDLE, 1'b0};
      expPad = osel ? data[0] : e[1];
      expOe  = osel ? oeReq   : e[0];
      checkOutput("pad", padOut, expPad);
      checkOutput("oe", oeOut, expOe);
    end
  end

  initial begin
    #2;
    checkOutput("initReady", ready, 1'b0);
    checkOutput("initBusy", busy, 1'b0);
    checkOutput("initPad", padOut, IDLE);
    checkOutput("initOe", oeOut, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

    // Single word 1011 with OE, then idle.
    applyStimulus(1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Back-to-back words A then 5 with valid held high.
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 4'h5, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Input changes mid-word must not disturb the word in flight.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Reset mid-word, then an accept on the first edge after release.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Bypass with data bit 0 and OE toggling every cycle.
    applyStimulus(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, W'(i % 2), 1'((i + 1) % 2), 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                    W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

    repeat (W + 2) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/out_ser_cell.md
OUT_SER_CELL -- requirements
Module: out_ser_cell

Interface
REQ-001 Parameter SER_WIDTH, default 4, parallel word width serialised to the pad; legal range 2..8.
REQ-002 Parameter IDLE_VAL, default 1'b0, pad data value driven while no word is being shifted.
REQ-003 IQC  input  1  clock; all state SHALL update on its rising edge.
REQ-004 QRT  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 F2A_DATA  input  SER_WIDTH  parallel word from fabric; bit 0 is transmitted first.
REQ-006 F2A_VALID  input  1  fabric presents a word on F2A_DATA.
REQ-007 OE_REQ  input  1  pad output-enable requested for the presented word.
REQ-008 OSEL  input  1  bypass select; 1 = pad driven combinationally from fabric.
REQ-009 F2A_READY  output  1  cell accepts a word this cycle.
REQ-010 BUSY  output  1  a word is being shifted out.
REQ-011 OQI_$out  output  1  pad data, carries the iopad_external_pin attribute.
REQ-012 OE_$out  output  1  pad output enable, carries the iopad_external_pin attribute.

Function
REQ-013 The block SHALL be a two-state FSM: IDLE, SHIFT; BUSY SHALL be 1 exactly in SHIFT.
REQ-014 A word SHALL be accepted on a rising IQC edge where F2A_VALID=1 and F2A_READY=1.
REQ-015 F2A_READY SHALL be 1 in IDLE, 1 in SHIFT only when the bit counter equals SER_WIDTH-1, and 0 otherwise, and 0 while QRT=1.
REQ-016 On accept, the shift register SHALL load F2A_DATA, the OE register SHALL load OE_REQ, the counter SHALL load 0, and the FSM SHALL enter SHIFT.
REQ-017 The registered pad data SHALL equal word bit k in the cycle after the k-th shifting edge (k=0..SER_WIDTH-1): first bit appears one cycle after the accept edge, with no gap.
REQ-018 The counter SHALL be ceil(log2(SER_WIDTH)) bits, increment once per cycle in SHIFT, and never exceed SER_WIDTH-1.
REQ-019 At counter SER_WIDTH-1 with F2A_VALID=1, the next word SHALL be accepted on that edge (back-to-back, zero idle bits between words).
REQ-020 At counter SER_WIDTH-1 with F2A_VALID=0, the FSM SHALL return to IDLE; next cycle registered pad data SHALL be IDLE_VAL and registered OE SHALL be 0.
REQ-021 Registered OE SHALL hold the accepted OE_REQ value for all SER_WIDTH bit cycles of that word; OE_REQ changes mid-word SHALL be ignored.
REQ-022 F2A_DATA and OE_REQ changes while F2A_READY=0 SHALL have no effect.
REQ-023 With OSEL=1, OQI_$out SHALL equal F2A_DATA[0] and OE_$out SHALL equal OE_REQ combinationally; with OSEL=0 they SHALL equal the registered pad data and registered OE.
REQ-024 OSEL SHALL only select outputs; the FSM, handshake and counter SHALL run identically for either OSEL value.

Reset
REQ-025 While QRT=1: state IDLE, counter 0, shift register 0, registered pad data IDLE_VAL, registered OE 0, BUSY 0, F2A_READY 0, regardless of IQC.
REQ-026 QRT asserted mid-word SHALL abort the word immediately; no remaining bits SHALL be emitted after QRT deasserts.
REQ-027 The first accept after QRT deasserts SHALL occur no earlier than the first rising IQC edge with QRT=0.

Verification
REQ-028 SER_WIDTH=4, OSEL=0, accept F2A_DATA=4'b1011 with OE_REQ=1, VALID then low -> OQI_$out 1,1,0,1 on cycles 1..4 after accept, OE_$out 1 for those 4 cycles, then OQI_$out=0, OE_$out=0, BUSY=0.
REQ-029 Words 4'hA then 4'h5 with VALID held high -> second word accepted at counter 3, OQI_$out 0,1,0,1,1,0,1,0 continuous, F2A_READY high only on cycles 0 and 4.
REQ-030 Accept 4'hF with OE_REQ=1, toggle OE_REQ to 0 and F2A_DATA to 0 during shifting -> OE_$out stays 1 and OQI_$out stays 1 for all 4 bits.
REQ-031 Assert QRT after 2nd bit of 4'hF -> OQI_$out=IDLE_VAL, OE_$out=0, BUSY=0, F2A_READY=0 immediately; after release, no residual bits and F2A_READY=1 next cycle.
REQ-032 OSEL=1 with F2A_DATA[0] and OE_REQ toggling every cycle -> OQI_$out/OE_$out follow combinationally; BUSY/F2A_READY sequencing identical to REQ-028.
